// File: rtl/mutative_switch_policy_if.sv
// Bundles the access-classification flags, the switch request handshake and the
// policy status outputs exchanged between the mutative cache controller and its policy block.
interface mutative_switch_policy_if #(
    parameter int SCORE_W = 16,
    parameter int WC_W    = 7
);
    logic                      access_valid;
    logic                      real_cache_valid;
    logic                      real_cache_hit;
    logic                      full_assoc_hit;
    logic                      real_cache_full;
    logic                      full_assoc_full;
    logic        [1:0]         setup;
    logic                      setup_ready;
    logic                      switch_valid;
    logic                      switch_dir;
    logic signed [SCORE_W-1:0] score;
    logic        [WC_W-1:0]    window_count;
    logic        [15:0]        switch_count;

    modport master (
        output access_valid, real_cache_valid, real_cache_hit, full_assoc_hit,
               real_cache_full, full_assoc_full, setup, setup_ready,
        input  switch_valid, switch_dir, score, window_count, switch_count
    );

    modport slave (
        input  access_valid, real_cache_valid, real_cache_hit, full_assoc_hit,
               real_cache_full, full_assoc_full, setup, setup_ready,
        output switch_valid, switch_dir, score, window_count, switch_count
    );
endinterface

// File: rtl/mutative_switch_policy.sv
// Scores conflict vs capacity misses over a fixed access window and requests an
// associativity step up or down from the cache controller at each window end.
module mutative_switch_policy #(
    parameter int WINDOW       = 64,
    parameter int UP_THRESH    = 32,
    parameter int DOWN_THRESH  = 16,
    parameter int CONFLICT_INC = 2,
    parameter int CAPACITY_DEC = 1,
    parameter int COOLDOWN     = 16,
    parameter int SCORE_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    mutative_switch_policy_if.slave  bus
);
    localparam int WC_W = $clog2(WINDOW) + 1;
    localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    localparam logic        [WC_W-1:0]    WC_LAST = WC_W'(WINDOW - 1);
    localparam logic        [CD_W-1:0]    CD_LAST = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    localparam logic signed [SCORE_W-1:0] UP_TH   = SCORE_W'(UP_THRESH);
    localparam logic signed [SCORE_W-1:0] DN_TH   = SCORE_W'(-DOWN_THRESH);
    localparam logic signed [SCORE_W-1:0] CONF_D  = SCORE_W'(CONFLICT_INC);
    localparam logic signed [SCORE_W-1:0] CAP_D   = SCORE_W'(-CAPACITY_DEC);

    typedef enum logic [1:0] {S_COUNT, S_EVAL, S_REQ, S_COOLDOWN} state_t;

    state_t                    state_q, state_d;
    logic signed [SCORE_W-1:0] score_q, score_d;
    logic        [WC_W-1:0]    wcnt_q, wcnt_d;
    logic        [CD_W-1:0]    cd_q, cd_d;
    logic        [15:0]        swcnt_q, swcnt_d;
    logic                      dir_q, dir_d;
    logic                      valid_q, valid_d;

    logic conflict_w, capacity_w, go_up_w, go_dn_w;

    // One extra bit of headroom exposes overflow as a sign mismatch.
    function automatic logic signed [SCORE_W-1:0] sat_add(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        logic signed [SCORE_W:0] s;
        s = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
        if (s[SCORE_W] != s[SCORE_W-1])
            sat_add = s[SCORE_W] ? {1'b1, {(SCORE_W-1){1'b0}}} : {1'b0, {(SCORE_W-1){1'b1}}};
        else
            sat_add = s[SCORE_W-1:0];
    endfunction

    assign conflict_w = bus.access_valid && bus.real_cache_valid && !bus.real_cache_hit &&
                        (bus.full_assoc_hit || !bus.real_cache_full);
    assign capacity_w = bus.access_valid && bus.real_cache_valid && !bus.real_cache_hit &&
                        !bus.full_assoc_hit && bus.real_cache_full && bus.full_assoc_full;
    assign go_up_w    = (score_q >= UP_TH) && (bus.setup != 2'd3);
    assign go_dn_w    = (score_q <= DN_TH) && (bus.setup != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_COUNT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COUNT:    if (bus.access_valid && wcnt_q == WC_LAST) state_d = S_EVAL;
            S_EVAL:     state_d = (go_up_w || go_dn_w) ? S_REQ : S_COUNT;
            S_REQ:      if (bus.setup_ready) state_d = (COOLDOWN == 0) ? S_COUNT : S_COOLDOWN;
            S_COOLDOWN: if (bus.access_valid && cd_q == CD_LAST) state_d = S_COUNT;
            default:    state_d = S_COUNT;
        endcase
    end

    always_comb begin
        score_d = score_q;
        wcnt_d  = wcnt_q;
        cd_d    = cd_q;
        swcnt_d = swcnt_q;
        dir_d   = dir_q;
        case (state_q)
            S_COUNT: begin
                if (bus.access_valid) wcnt_d = wcnt_q + WC_W'(1);
                if (conflict_w)      score_d = sat_add(score_q, CONF_D);
                else if (capacity_w) score_d = sat_add(score_q, CAP_D);
            end
            S_EVAL: begin
                score_d = '0;
                wcnt_d  = '0;
                cd_d    = '0;
                if (go_up_w)      dir_d = 1'b1;
                else if (go_dn_w) dir_d = 1'b0;
            end
            S_REQ: begin
                cd_d = '0;
                if (bus.setup_ready) swcnt_d = swcnt_q + 16'd1;
            end
            S_COOLDOWN: begin
                if (bus.access_valid) cd_d = cd_q + CD_W'(1);
                if (state_d == S_COUNT) begin
                    score_d = '0;
                    wcnt_d  = '0;
                end
            end
            default: ;
        endcase
        valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            score_q <= '0;
            wcnt_q  <= '0;
            cd_q    <= '0;
            swcnt_q <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            score_q <= score_d;
            wcnt_q  <= wcnt_d;
            cd_q    <= cd_d;
            swcnt_q <= swcnt_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
        end
    end

    assign bus.switch_valid = valid_q;
    assign bus.switch_dir   = dir_q;
    assign bus.score        = score_q;
    assign bus.window_count = wcnt_q;
    assign bus.switch_count = swcnt_q;
endmodule

// File: tb/tb_mutative_switch_policy.sv
// Directed scenarios followed by randomized traffic, every cycle compared against
// an access-level reference model of the switch policy.
module tb_mutative_switch_policy;
    localparam int WINDOW = 64;
    localparam int UP     = 32;
    localparam int DN     = 16;
    localparam int CINC   = 2;
    localparam int CDEC   = 1;
    localparam int COOL   = 16;
    localparam int SW     = 16;
    localparam int WCW    = $clog2(WINDOW) + 1;
    localparam int SMAX   = (1 << (SW - 1)) - 1;
    localparam int SMIN   = -(1 << (SW - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mutative_switch_policy_if #(.SCORE_W(SW), .WC_W(WCW)) bus ();

    mutative_switch_policy #(
        .WINDOW(WINDOW), .UP_THRESH(UP), .DOWN_THRESH(DN), .CONFLICT_INC(CINC),
        .CAPACITY_DEC(CDEC), .COOLDOWN(COOL), .SCORE_W(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: window accounting at access granularity.
    int m_score = 0;
    int m_cnt   = 0;
    int m_cool  = 0;
    int m_sc    = 0;
    bit m_eval  = 0;
    bit m_req   = 0;
    bit m_cool_on = 0;
    bit m_dir   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    task automatic model_edge();
        int delta;
        if (!rst) begin
            m_score = 0; m_cnt = 0; m_cool = 0; m_sc = 0;
            m_eval = 0; m_req = 0; m_cool_on = 0; m_dir = 0;
        end else if (m_eval) begin
            if (m_score >= UP && bus.setup < 3) begin
                m_req = 1; m_dir = 1;
            end else if (m_score <= -DN && bus.setup > 0) begin
                m_req = 1; m_dir = 0;
            end
            m_score = 0; m_cnt = 0; m_eval = 0;
        end else if (m_req) begin
            if (bus.setup_ready) begin
                m_sc = (m_sc + 1) % 65536;
                m_req = 0;
                m_cool_on = (COOL > 0);
                m_cool = 0;
            end
        end else if (m_cool_on) begin
            if (bus.access_valid) begin
                m_cool++;
                if (m_cool == COOL) begin
                    m_cool_on = 0; m_score = 0; m_cnt = 0;
                end
            end
        end else if (bus.access_valid) begin
            delta = 0;
            if (bus.real_cache_valid && !bus.real_cache_hit) begin
                if (bus.full_assoc_hit || !bus.real_cache_full) delta = CINC;
                else if (bus.full_assoc_full) delta = -CDEC;
            end
            m_score = clamp(m_score + delta);
            m_cnt++;
            if (m_cnt == WINDOW) m_eval = 1;
        end
    endtask

    task automatic compare_all();
        check("switch_valid", bus.switch_valid, m_req);
        check("switch_dir", bus.switch_dir, m_dir);
        check("score", longint'($signed(bus.score)), m_score);
        check("window_count", bus.window_count, m_cnt);
        check("switch_count", bus.switch_count, m_sc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // kind: 0 conflict, 1 capacity, 2 hit, 3 compulsory (real_cache_valid=0)
    task automatic set_flags(input int kind);
        bus.real_cache_valid = (kind != 3);
        bus.real_cache_hit   = (kind == 2);
        bus.full_assoc_hit   = (kind == 0) || (kind == 3);
        bus.real_cache_full  = 1'b1;
        bus.full_assoc_full  = 1'b1;
    endtask

    task automatic acc(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            set_flags(kind);
            bus.access_valid = 1'b1;
            step();
        end
        bus.access_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.access_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int mode;
        int r;
        bus.access_valid = 1'b0;
        bus.setup_ready  = 1'b0;
        bus.setup        = 2'd0;
        set_flags(2);
        rst = 1'b0;
        idle(2);
        check("reset_score", longint'($signed(bus.score)), 0);
        check("reset_valid", bus.switch_valid, 0);
        rst = 1'b1;

        // Conflict-heavy window from direct-mapped: step-up request, then handshake.
        bus.setup = 2'd0;
        acc(0, 63);
        check("t1_score63", longint'($signed(bus.score)), 126);
        acc(0, 1);
        check("t1_peak", longint'($signed(bus.score)), 128);
        check("t1_wc", bus.window_count, 64);
        idle(1);
        check("t1_valid", bus.switch_valid, 1);
        check("t1_dir", bus.switch_dir, 1);
        idle(5);
        check("t1_hold_valid", bus.switch_valid, 1);
        check("t1_hold_dir", bus.switch_dir, 1);
        bus.setup_ready = 1'b1;
        step();
        bus.setup_ready = 1'b0;
        check("t1_drop", bus.switch_valid, 0);
        check("t1_swc", bus.switch_count, 1);

        // Cooldown swallows the next 16 accesses.
        acc(0, 16);
        check("t5_cool_score", longint'($signed(bus.score)), 0);
        check("t5_cool_wc", bus.window_count, 0);
        acc(0, 1);
        check("t5_wc1", bus.window_count, 1);
        check("t5_score2", longint'($signed(bus.score)), 2);
        acc(2, 63);
        idle(2);
        check("t5_noreq", bus.switch_valid, 0);

        // Capacity-heavy window: step-down request.
        bus.setup = 2'd2;
        acc(1, 64);
        check("t2_score", longint'($signed(bus.score)), -64);
        idle(1);
        check("t2_valid", bus.switch_valid, 1);
        check("t2_dir", bus.switch_dir, 0);
        bus.setup_ready = 1'b1;
        step();
        bus.setup_ready = 1'b0;
        check("t2_swc", bus.switch_count, 2);
        acc(2, 16);

        // Already at max associativity: no request.
        bus.setup = 2'd3;
        acc(0, 64);
        idle(1);
        check("t3_noreq", bus.switch_valid, 0);
        check("t3_score0", longint'($signed(bus.score)), 0);
        check("t3_wc0", bus.window_count, 0);
        acc(2, 1);
        check("t3_counting", bus.window_count, 1);
        acc(2, 63);
        idle(2);

        // Mixed window lands between thresholds.
        bus.setup = 2'd1;
        acc(0, 20);
        acc(1, 30);
        acc(2, 14);
        check("t4_score", longint'($signed(bus.score)), 10);
        idle(1);
        check("t4_noreq", bus.switch_valid, 0);
        check("t4_restart", bus.window_count, 0);

        // Reset while a request is pending.
        bus.setup = 2'd0;
        acc(0, 64);
        idle(1);
        check("t6_pending", bus.switch_valid, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t6_valid", bus.switch_valid, 0);
        check("t6_score", longint'($signed(bus.score)), 0);
        check("t6_swc", bus.switch_count, 0);
        acc(3, 64);
        idle(3);
        check("t6_invalid_noreq", bus.switch_valid, 0);

        // Randomized traffic with per-window bias.
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) begin
                mode = $urandom_range(0, 2);
                bus.setup = 2'($urandom_range(0, 3));
            end
            r = $urandom_range(0, 99);
            if (mode == 0)      set_flags((r < 70) ? 0 : (r < 80) ? 1 : (r < 90) ? 2 : 3);
            else if (mode == 1) set_flags((r < 70) ? 1 : (r < 80) ? 0 : (r < 90) ? 2 : 3);
            else begin
                bus.real_cache_valid = 1'($urandom);
                bus.real_cache_hit   = 1'($urandom);
                bus.full_assoc_hit   = 1'($urandom);
                bus.real_cache_full  = 1'($urandom);
                bus.full_assoc_full  = 1'($urandom);
            end
            bus.access_valid = ($urandom_range(0, 3) != 0);
            bus.setup_ready  = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 999) != 0);
            step();
        end
        rst = 1'b1;
        bus.access_valid = 1'b0;
        bus.setup_ready  = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mutative_switch_policy.md
Name: mutative_switch_policy

Overview:
Generates the associativity switch requests (switch_valid/switch_dir) consumed by the mutative cache controller, which acknowledges them with setup_ready. It classifies every completed CPU access as conflict miss, capacity miss or other, accumulates a saturating signed score over a fixed access window, and at window end decides whether to request a step up (more associative) or a step down in setup. It sits beside the controller and is fed by the same real-cache and shadow fully-associative hit/full flags.

Parameters:
WINDOW, 64, accesses per evaluation window (>=2)
UP_THRESH, 32, score >= this requests a step up
DOWN_THRESH, 16, score <= -DOWN_THRESH requests a step down
CONFLICT_INC, 2, score added per conflict miss
CAPACITY_DEC, 1, score subtracted per capacity miss
COOLDOWN, 16, accesses ignored after a completed handshake
SCORE_W, 16, score width, two's complement

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
access_valid  input  1  one-cycle pulse per completed CPU access; flags below are sampled only when it is high
real_cache_valid  input  1  access is not a compulsory miss
real_cache_hit  input  1  real cache hit
full_assoc_hit  input  1  shadow fully-associative hit
real_cache_full  input  1  real cache set full
full_assoc_full  input  1  shadow cache full
setup  input  2  current controller configuration, 0=DM .. 3=max associativity
setup_ready  input  1  controller acknowledge of switch request
switch_valid  output  1  switch request pending
switch_dir  output  1  1=step up, 0=step down
score  output  SCORE_W  current accumulated score, signed
window_count  output  clog2(WINDOW)+1  accesses counted in current window
switch_count  output  16  completed handshakes, wraps at 2^16

Behaviour:
- Reset (rst=0 at clk edge): state=S_COUNT; switch_valid=0, switch_dir=0, score=0, window_count=0, switch_count=0, cooldown counter=0. Reset in any state, including S_REQ, drops switch_valid the following cycle; no handshake is completed.
- Classification, only when access_valid=1 and real_cache_valid=1:
  conflict = !real_cache_hit && (full_assoc_hit || !real_cache_full) -> score += CONFLICT_INC
  capacity = !real_cache_hit && !full_assoc_hit && real_cache_full && full_assoc_full -> score -= CAPACITY_DEC
  otherwise no change. real_cache_valid=0 accesses count toward the window but leave the score unchanged.
- Score saturates at +(2^(SCORE_W-1)-1) and -2^(SCORE_W-1); never wraps.
- States:
  S_COUNT: each access_valid updates score and increments window_count. The access that makes window_count == WINDOW registers its score contribution, then moves to S_EVAL.
  S_EVAL (1 cycle): up if score>=UP_THRESH and setup<3; else down if score<=-DOWN_THRESH and setup>0; else none. Up or down -> S_REQ with switch_dir latched. None -> S_COUNT. In both cases score=0 and window_count=0 on exit. Accesses arriving in S_EVAL are dropped.
  S_REQ: switch_valid=1, switch_dir held stable. setup_ready=1 in any S_REQ cycle completes the handshake: switch_count+1, switch_valid=0 next cycle, then S_COOLDOWN. Accesses are dropped. No timeout.
  S_COOLDOWN: counts access_valid pulses and ignores their flags. After COOLDOWN pulses -> S_COUNT with score=0 and window_count=0. COOLDOWN=0 goes directly to S_COUNT.
- switch_valid is registered and asserted only in S_REQ. setup_ready outside S_REQ is ignored.
- Request latency: switch_valid rises 2 cycles after the window-completing access_valid.

Test Plan:
1. setup=0, 64 conflict accesses (valid=1, hit=0, fa_hit=1) -> score peaks at 128; switch_valid=1, dir=1 two cycles after the 64th access. Hold setup_ready=0 for 5 cycles: valid and dir stay stable. Pulse setup_ready=1: valid=0 next cycle, switch_count=1.
2. setup=2, 64 capacity misses (all full flags=1, hits=0) -> score=-64; request with dir=0. Handshake completes.
3. setup=3, 64 conflict accesses -> no switch_valid; score and window_count return to 0; state is back in S_COUNT.
4. 20 conflict, 30 capacity, 14 hits -> score=10 at eval; no request; next window starts from 0.
5. After the handshake in test 1, 16 conflict accesses -> score stays 0 and window_count stays 0. The 17th access -> window_count=1, score=2.
6. rst=0 asserted while switch_valid=1 -> switch_valid=0, score=0, switch_count=0 the next cycle. 64 real_cache_valid=0 accesses then produce no request.
